// File: rtl/hack_pkg.sv
// Shared types and constants for the multi-cycle Hack CPU sequencer:
// FSM state encoding, instruction-register field positions and jump codes.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEMRD  = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam int IR_CBIT    = 15;
  localparam int IR_ABIT    = 12;
  localparam int IR_COMP_HI = 11;
  localparam int IR_COMP_LO = 6;
  localparam int IR_DEST_A  = 5;
  localparam int IR_DEST_D  = 4;
  localparam int IR_DEST_M  = 3;
  localparam int IR_JMP_HI  = 2;
  localparam int IR_JMP_LO  = 0;

  typedef logic [5:0] alu_ctl_t;

  localparam logic [2:0] JMP_NULL = 3'b000;
  localparam logic [2:0] JMP_JGT  = 3'b001;
  localparam logic [2:0] JMP_JEQ  = 3'b010;
  localparam logic [2:0] JMP_JGE  = 3'b011;
  localparam logic [2:0] JMP_JLT  = 3'b100;
  localparam logic [2:0] JMP_JNE  = 3'b101;
  localparam logic [2:0] JMP_JLE  = 3'b110;
  localparam logic [2:0] JMP_JMP  = 3'b111;

  function automatic logic is_uncond_jump(input logic [2:0] j);
    return j == JMP_JMP;
  endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational Hack jump decision from the jump field and latched ALU flags.
module hack_jump_cond (
  input  logic [2:0] i_j,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_jump
);

  // The three jump bits select lt / eq / gt; positive means neither zero nor negative.
  assign o_jump = (i_j[2] & i_ng) | (i_j[1] & i_zr) | (i_j[0] & ~i_ng & ~i_zr);

endmodule

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer around an external ALU, with ROM fetch and M req/ack port.
// Optional halt-on-self-loop detection is built when HACK_HALT_DETECT_EN is defined.
module hack_cpu_seq
  import hack_pkg::*;
#(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [15:0]     rom_data,
  output logic            ram_rd,
  output logic            ram_wr,
  output logic [PC_W-1:0] ram_addr,
  output logic [15:0]     ram_wdata,
  input  logic            ram_ack,
  input  logic [15:0]     ram_rdata,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output alu_ctl_t        alu_ctl,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng,
  output logic [PC_W-1:0] pc,
  output logic            instr_done,
  output logic            halted
);

  state_t          r_state;
  logic [15:0]     r_a;
  logic [15:0]     r_d;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [15:0]     r_mdr;
  logic [15:0]     r_r;
  logic            r_zr;
  logic            r_ng;
  logic            r_halted;

  logic            w_jump;
  logic            w_commit;
  logic            w_a_done;
  logic            w_halt_hit;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_unused_ir;

  hack_jump_cond u_jump_cond (
    .i_j    (r_ir[IR_JMP_HI:IR_JMP_LO]),
    .i_zr   (r_zr),
    .i_ng   (r_ng),
    .o_jump (w_jump)
  );

  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_unused_ir = ^r_ir[14:13];
  assign w_a_done    = (r_state == DECODE) && !r_ir[IR_CBIT];
  // A write-back without an M destination commits without waiting for any ack.
  assign w_commit    = (r_state == WB) && (!r_ir[IR_DEST_M] || ram_ack);

`ifdef HACK_HALT_DETECT_EN
  assign w_halt_hit = is_uncond_jump(r_ir[IR_JMP_HI:IR_JMP_LO]) && (r_a[PC_W-1:0] == r_pc);
`else
  assign w_halt_hit = 1'b0;
`endif

  assign rom_req    = !reset && (r_state == FETCH);
  assign ram_rd     = !reset && (r_state == MEMRD);
  assign ram_wr     = !reset && (r_state == WB) && r_ir[IR_DEST_M];
  assign instr_done = !reset && (w_a_done || w_commit);
  assign rom_addr   = r_pc;
  assign pc         = r_pc;
  assign ram_addr   = r_a[PC_W-1:0];
  assign ram_wdata  = r_r;
  assign alu_x      = r_d;
  assign alu_y      = r_ir[IR_ABIT] ? r_mdr : r_a;
  assign alu_ctl    = r_ir[IR_COMP_HI:IR_COMP_LO];
  assign halted     = r_halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_a      <= '0;
      r_d      <= '0;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_r      <= '0;
      r_zr     <= 1'b0;
      r_ng     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        FETCH: if (rom_ack) begin
          r_ir    <= rom_data;
          r_state <= DECODE;
        end
        DECODE: begin
          if (!r_ir[IR_CBIT]) begin
            r_a     <= r_ir;
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
          end else if (r_ir[IR_ABIT]) begin
            r_state <= MEMRD;
          end else begin
            r_state <= EXEC;
          end
        end
        MEMRD: if (ram_ack) begin
          r_mdr   <= ram_rdata;
          r_state <= EXEC;
        end
        EXEC: begin
          r_r     <= alu_out;
          r_zr    <= alu_zr;
          r_ng    <= alu_ng;
          r_state <= WB;
        end
        WB: if (w_commit) begin
          // Jump target reads r_a before the A destination update lands.
          if (r_ir[IR_DEST_A]) r_a <= r_r;
          if (r_ir[IR_DEST_D]) r_d <= r_r;
          r_pc <= w_jump ? r_a[PC_W-1:0] : w_pc_inc;
          if (w_halt_hit) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_state  <= FETCH;
          end
        end
        HALT: r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
